comparator_serial_n_bit: RTL and testbench
==========================================

Name: comparator_serial_n_bit

Overview:
Parametrised, digit-serial magnitude comparator for DATA_WIDTH-bit operands, with selectable unsigned or two's-complement signed mode. It examines DIGIT_WIDTH bits per clock, MSB digit first, and terminates early on the first differing digit. A start/busy/done handshake makes it usable as a shared compare resource in datapaths where a full-width combinational comparator is too costly in area or timing. It is the multi-cycle, wide-operand successor to the fixed 2-bit combinational comparator.

Parameters:
DATA_WIDTH, 16, operand width in bits; must be ≥ 2.
DIGIT_WIDTH, 2, bits compared per cycle; must divide DATA_WIDTH. Elaboration error otherwise.
NUM_DIGITS, DATA_WIDTH/DIGIT_WIDTH, derived localparam; do not override.

Ports:
Clock_In  input  1  rising-edge clock.
Reset_In  input  1  synchronous, active-high reset.
Start_In  input  1  request a compare; sampled on the rising edge.
Signed_Mode_In  input  1  1 = two's-complement compare, 0 = unsigned; captured with the operands.
Data_A_In  input  DATA_WIDTH  operand A; captured on an accepted start.
Data_B_In  input  DATA_WIDTH  operand B; captured on an accepted start.
Busy_Out  output  1  high while in COMPARE.
Done_Out  output  1  one-cycle pulse: result valid.
A_Less_Than_B_Out  output  1  result flag.
A_Equal_To_B_Out  output  1  result flag.
A_Greater_Than_B_Out  output  1  result flag.
Digit_Count_Out  output  $clog2(NUM_DIGITS+1)  number of digits examined for the last result.

Behaviour:
- One clock domain. Reset is synchronous and active-high. Clock and reset ports are named Clock_In and Reset_In.
- Reset (priority over everything): state = IDLE. All outputs are 0. Digit index and captured operands are cleared.
- States: IDLE, COMPARE, DONE.
- Start acceptance: Start_In = 1 is accepted in IDLE or DONE. On the accepting edge:
  - capture A, B and mode;
  - in signed mode, invert the MSB of both captured operands, then compare as unsigned;
  - digit index = 0 (most significant digit);
  - clear all three flags and Digit_Count_Out;
  - next state = COMPARE.
- Start_In is ignored while in COMPARE. Input changes after capture have no effect.
- COMPARE, each edge, compare digit[index] of A against digit[index] of B:
  - Digits differ: set the LT or GT flag, set Digit_Count_Out = index+1, go to DONE.
  - Digits equal and index = NUM_DIGITS-1: set the EQ flag, set Digit_Count_Out = NUM_DIGITS, go to DONE.
  - Otherwise: index += 1.
- DONE: Done_Out = 1 for exactly this one cycle. Busy_Out = 0.
  - Next state is IDLE, or COMPARE if Start_In is accepted in this same cycle (back-to-back operation, no bubble).
- Latency: let j be the index of the first differing digit, or NUM_DIGITS-1 if the operands are equal. Done_Out is high in the cycle following the (j+1)-th rising edge after the accepting edge. Minimum latency is 1 edge; maximum is NUM_DIGITS edges.
- Flags:
  - 0 from acceptance until the result is produced.
  - After a result, exactly one flag is 1. Flags and Digit_Count_Out hold their values through IDLE until the next accepted start.
- Reset mid-operation: abort the compare. No Done_Out pulse, flags = 0.

Decomposition:
- Shared package comparator_pkg holds:
  - the state enum (IDLE/COMPARE/DONE);
  - the result encoding enum (CMP_LT/CMP_EQ/CMP_GT);
  - a helper function for the signed-to-unsigned MSB flip.
- One sub-module: comparator_digit.
  - Combinational, parametrised by DIGIT_WIDTH.
  - Outputs lt/eq/gt for one digit pair.
  - Instantiated once, fed by index-muxed digit slices.

Test Plan (DATA_WIDTH=8, DIGIT_WIDTH=2, NUM_DIGITS=4):
1. Hold Reset_In high for 2 cycles with Start_In=1 -> all outputs 0, no Done_Out, state IDLE after reset releases.
2. Unsigned, A=0xC3, B=0x43 -> first digits 11 vs 01 differ; Done_Out after 1 edge; GT=1; Digit_Count_Out=1; Busy_Out high for exactly 1 cycle.
3. Unsigned, A=0x5A, B=0x5A -> Done_Out after 4 edges; EQ=1; Digit_Count_Out=4. Then A=0x12, B=0x13 -> LT=1 at digit 3; Digit_Count_Out=4; Start_In pulsed during COMPARE is ignored.
4. A=0x80, B=0x01: Signed_Mode_In=1 -> LT=1 (-128 < 1); repeat with Signed_Mode_In=0 -> GT=1 (128 > 1). Also signed A=0xFF, B=0xFE -> GT=1.
5. Back-to-back: Start_In asserted in the DONE cycle with A=0x00, B=0x40 -> no idle bubble; flags clear, then LT=1 after 1 edge.
6. Start A=0x00, B=0x00; assert Reset_In on the 2nd edge after acceptance -> no Done_Out, flags 0, Busy_Out 0. A subsequent start completes normally with EQ=1.

Source files
------------

// File: rtl/comparator_pkg.sv
// ============================================================================
// Module   : comparator_pkg
// Purpose  : Shared types and helpers for the digit-serial magnitude comparator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package comparator_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPARE = 2'd1,
      DONE    = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      CMP_LT = 2'd0,
      CMP_EQ = 2'd1,
      CMP_GT = 2'd2
   } cmp_result_t;

   // Biasing the sign bit maps two's-complement order onto unsigned order.
   function automatic logic to_unsigned_msb(input logic msb, input logic signed_mode);
      return msb ^ signed_mode;
   endfunction

endpackage

`default_nettype wire

// File: rtl/comparator_serial_n_bit_if.sv
// ============================================================================
// Module   : comparator_serial_n_bit_if
// Purpose  : Start/busy/done handshake and operand/result bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface comparator_serial_n_bit_if #(
   parameter int DATA_WIDTH  = 16,
   parameter int DIGIT_WIDTH = 2
);
   localparam int NUM_DIGITS = DATA_WIDTH / DIGIT_WIDTH;
   localparam int CNT_W      = $clog2(NUM_DIGITS + 1);

   logic                  Start_In;
   logic                  Signed_Mode_In;
   logic [DATA_WIDTH-1:0] Data_A_In;
   logic [DATA_WIDTH-1:0] Data_B_In;
   logic                  Busy_Out;
   logic                  Done_Out;
   logic                  A_Less_Than_B_Out;
   logic                  A_Equal_To_B_Out;
   logic                  A_Greater_Than_B_Out;
   logic [CNT_W-1:0]      Digit_Count_Out;

   modport master (
      output Start_In, Signed_Mode_In, Data_A_In, Data_B_In,
      input  Busy_Out, Done_Out, A_Less_Than_B_Out, A_Equal_To_B_Out,
             A_Greater_Than_B_Out, Digit_Count_Out
   );

   modport slave (
      input  Start_In, Signed_Mode_In, Data_A_In, Data_B_In,
      output Busy_Out, Done_Out, A_Less_Than_B_Out, A_Equal_To_B_Out,
             A_Greater_Than_B_Out, Digit_Count_Out
   );

endinterface

`default_nettype wire

// File: rtl/comparator_digit.sv
// ============================================================================
// Module   : comparator_digit
// Purpose  : Combinational unsigned compare of one digit pair.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module comparator_digit #(
   parameter int DIGIT_WIDTH = 2
) (
   input  wire logic [DIGIT_WIDTH-1:0] i_digit_a,
   input  wire logic [DIGIT_WIDTH-1:0] i_digit_b,
   output logic                        o_lt,
   output logic                        o_eq,
   output logic                        o_gt
);

   assign o_lt = (i_digit_a <  i_digit_b);
   assign o_eq = (i_digit_a == i_digit_b);
   assign o_gt = (i_digit_a >  i_digit_b);

endmodule

`default_nettype wire

// File: rtl/comparator_serial_n_bit.sv
// ============================================================================
// Module   : comparator_serial_n_bit
// Purpose  : Digit-serial MSB-first magnitude comparator with early exit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module comparator_serial_n_bit
   import comparator_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int DIGIT_WIDTH = 2
) (
   input wire logic                  Clock_In,
   input wire logic                  Reset_In,
   comparator_serial_n_bit_if.slave  cmp_if
);

   localparam int NUM_DIGITS = DATA_WIDTH / DIGIT_WIDTH;
   localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CNT_W      = $clog2(NUM_DIGITS + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

   if ((DATA_WIDTH < 2) || (DIGIT_WIDTH < 1) || ((DATA_WIDTH % DIGIT_WIDTH) != 0)) begin : g_param_check
      $error("comparator_serial_n_bit: DIGIT_WIDTH must divide DATA_WIDTH and DATA_WIDTH >= 2");
   end

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [DATA_WIDTH-1:0]  a_q, a_d;
   logic [DATA_WIDTH-1:0]  b_q, b_d;
   logic                   lt_q, lt_d;
   logic                   eq_q, eq_d;
   logic                   gt_q, gt_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;

   logic [DIGIT_WIDTH-1:0] w_digits_a [NUM_DIGITS];
   logic [DIGIT_WIDTH-1:0] w_digits_b [NUM_DIGITS];
   logic                   w_dig_lt, w_dig_eq, w_dig_gt;
   cmp_result_t            w_dig_res;
   logic                   w_accept;

   // Array entry 0 holds the most significant digit.
   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digits
      assign w_digits_a[gi] = a_q[(NUM_DIGITS-1-gi)*DIGIT_WIDTH +: DIGIT_WIDTH];
      assign w_digits_b[gi] = b_q[(NUM_DIGITS-1-gi)*DIGIT_WIDTH +: DIGIT_WIDTH];
   end

   comparator_digit #(
      .DIGIT_WIDTH (DIGIT_WIDTH)
   ) u_digit (
      .i_digit_a (w_digits_a[idx_q]),
      .i_digit_b (w_digits_b[idx_q]),
      .o_lt      (w_dig_lt),
      .o_eq      (w_dig_eq),
      .o_gt      (w_dig_gt)
   );

   always_comb begin
      w_dig_res = CMP_EQ;
      case ({w_dig_lt, w_dig_eq, w_dig_gt})
         3'b100:  w_dig_res = CMP_LT;
         3'b001:  w_dig_res = CMP_GT;
         default: w_dig_res = CMP_EQ;
      endcase
   end

   assign w_accept = cmp_if.Start_In && (state_q != COMPARE);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      lt_d    = lt_q;
      eq_d    = eq_q;
      gt_d    = gt_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         COMPARE: begin
            if ((w_dig_res != CMP_EQ) || (idx_q == LAST_IDX)) begin
               lt_d    = (w_dig_res == CMP_LT);
               eq_d    = (w_dig_res == CMP_EQ);
               gt_d    = (w_dig_res == CMP_GT);
               cnt_d   = CNT_W'(idx_q) + CNT_W'(1);
               state_d = DONE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // A start in DONE overrides the return to IDLE, giving back-to-back compares.
      if (w_accept) begin
         a_d     = {to_unsigned_msb(cmp_if.Data_A_In[DATA_WIDTH-1], cmp_if.Signed_Mode_In),
                    cmp_if.Data_A_In[DATA_WIDTH-2:0]};
         b_d     = {to_unsigned_msb(cmp_if.Data_B_In[DATA_WIDTH-1], cmp_if.Signed_Mode_In),
                    cmp_if.Data_B_In[DATA_WIDTH-2:0]};
         idx_d   = '0;
         lt_d    = 1'b0;
         eq_d    = 1'b0;
         gt_d    = 1'b0;
         cnt_d   = '0;
         state_d = COMPARE;
      end

      busy_d = (state_d == COMPARE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge Clock_In) begin
      if (Reset_In) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         lt_q    <= 1'b0;
         eq_q    <= 1'b0;
         gt_q    <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         lt_q    <= lt_d;
         eq_q    <= eq_d;
         gt_q    <= gt_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign cmp_if.Busy_Out             = busy_q;
   assign cmp_if.Done_Out             = done_q;
   assign cmp_if.A_Less_Than_B_Out    = lt_q;
   assign cmp_if.A_Equal_To_B_Out     = eq_q;
   assign cmp_if.A_Greater_Than_B_Out = gt_q;
   assign cmp_if.Digit_Count_Out      = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_comparator_serial_n_bit.sv
// ============================================================================
// Module   : tb_comparator_serial_n_bit
// Purpose  : Self-checking bench for the digit-serial comparator (8-bit, 2-bit digits).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_comparator_serial_n_bit;

   localparam int DW = 8;
   localparam int GW = 2;
   localparam int ND = DW / GW;
   localparam int CW = $clog2(ND + 1);

   typedef struct {
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic          mode;
      logic          lt;
      logic          eq;
      logic          gt;
      logic [CW-1:0] cnt;
   } vec_t;

   typedef struct {
      logic          lt;
      logic          eq;
      logic          gt;
      logic [CW-1:0] cnt;
      int            exp_cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   comparator_serial_n_bit_if #(.DATA_WIDTH(DW), .DIGIT_WIDTH(GW)) cmp_if ();

   comparator_serial_n_bit #(
      .DATA_WIDTH  (DW),
      .DIGIT_WIDTH (GW)
   ) dut (
      .Clock_In (clk),
      .Reset_In (rst),
      .cmp_if   (cmp_if)
   );

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   busy_cycles = 0;
   exp_t sb[$];
   exp_t last_exp;
   exp_t mon_e;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic int flags3();
      return int'({cmp_if.A_Less_Than_B_Out, cmp_if.A_Equal_To_B_Out, cmp_if.A_Greater_Than_B_Out});
   endfunction

   function automatic int all_outs();
      return int'({cmp_if.Busy_Out, cmp_if.Done_Out, cmp_if.A_Less_Than_B_Out,
                   cmp_if.A_Equal_To_B_Out, cmp_if.A_Greater_Than_B_Out, cmp_if.Digit_Count_Out});
   endfunction

   // Reference: integer compare for the flags, highest differing bit for the digit count.
   function automatic vec_t model(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic mode);
      vec_t          v;
      logic [DW-1:0] d;
      int            idx;
      bit            found;
      v.a = a; v.b = b; v.mode = mode;
      if (mode) begin
         v.lt = ($signed(a) < $signed(b));
         v.gt = ($signed(a) > $signed(b));
      end else begin
         v.lt = (a < b);
         v.gt = (a > b);
      end
      v.eq  = (a == b);
      d     = a ^ b;
      idx   = ND - 1;
      found = 1'b0;
      for (int p = DW - 1; p >= 0; p--) begin
         if (d[p] && !found) begin
            idx   = (DW - 1 - p) / GW;
            found = 1'b1;
         end
      end
      v.cnt = CW'(idx + 1);
      return v;
   endfunction

   // Scoreboard consumer: every Done_Out pulse pops one expected result.
   always @(negedge clk) begin
      if (rst) begin
         busy_cycles = 0;
      end else begin
         if (cmp_if.Busy_Out) begin
            busy_cycles++;
            check("flags_clear_while_busy", flags3(), 0);
         end
         if (cmp_if.Done_Out) begin
            if (sb.size() == 0) begin
               check("spurious_done", 1, 0);
            end else begin
               mon_e = sb.pop_front();
               check("done_cycle", cyc, mon_e.exp_cyc);
               check("lt_flag", int'(cmp_if.A_Less_Than_B_Out), int'(mon_e.lt));
               check("eq_flag", int'(cmp_if.A_Equal_To_B_Out), int'(mon_e.eq));
               check("gt_flag", int'(cmp_if.A_Greater_Than_B_Out), int'(mon_e.gt));
               check("digit_count", int'(cmp_if.Digit_Count_Out), int'(mon_e.cnt));
               check("busy_cycles", busy_cycles, int'(mon_e.cnt));
               check("busy_low_at_done", int'(cmp_if.Busy_Out), 0);
               last_exp = mon_e;
            end
            busy_cycles = 0;
         end
      end
   end

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic start_cmp(input vec_t v, input bit push);
      exp_t e;
      cmp_if.Data_A_In      = v.a;
      cmp_if.Data_B_In      = v.b;
      cmp_if.Signed_Mode_In = v.mode;
      cmp_if.Start_In       = 1'b1;
      if (push) begin
         e.lt = v.lt; e.eq = v.eq; e.gt = v.gt; e.cnt = v.cnt;
         e.exp_cyc = cyc + 1 + int'(v.cnt);
         sb.push_back(e);
      end
      @(posedge clk); #1;
      cmp_if.Start_In = 1'b0;
   endtask

   task automatic wait_drain();
      int k;
      k = 0;
      while ((sb.size() != 0) && (k < 20)) begin
         @(posedge clk);
         k++;
      end
      #1;
      if (sb.size() != 0) begin
         check("done_timeout", int'(sb.size()), 0);
         sb.delete();
      end
      @(negedge clk);
      check("flags_hold_idle", flags3(), int'({last_exp.lt, last_exp.eq, last_exp.gt}));
      check("count_hold_idle", int'(cmp_if.Digit_Count_Out), int'(last_exp.cnt));
      check("idle_busy_done_low", int'({cmp_if.Busy_Out, cmp_if.Done_Out}), 0);
      @(posedge clk); #1;
   endtask

   vec_t vecs[11];

   initial begin
      vec_t v;
      logic [DW-1:0] ra;

      vecs[0]  = '{8'hC3, 8'h43, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1};
      vecs[1]  = '{8'h5A, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4};
      vecs[2]  = '{8'h12, 8'h13, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4};
      vecs[3]  = '{8'h80, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1};
      vecs[4]  = '{8'h80, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1};
      vecs[5]  = '{8'hFF, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4};
      vecs[6]  = '{8'h34, 8'h38, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3};
      vecs[7]  = '{8'h7F, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1};
      vecs[8]  = '{8'h24, 8'h14, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2};
      vecs[9]  = '{8'hF0, 8'hF1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4};
      vecs[10] = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4};

      // Reset held with a pending start request.
      rst = 1'b1;
      cmp_if.Start_In       = 1'b1;
      cmp_if.Data_A_In      = 8'hAA;
      cmp_if.Data_B_In      = 8'h55;
      cmp_if.Signed_Mode_In = 1'b0;
      @(posedge clk); #1;
      check("reset_outputs_1", all_outs(), 0);
      @(posedge clk); #1;
      check("reset_outputs_2", all_outs(), 0);
      rst = 1'b0;
      cmp_if.Start_In = 1'b0;
      @(posedge clk); #1;
      check("idle_after_reset", all_outs(), 0);

      for (int i = 0; i < 11; i++) begin
         start_cmp(vecs[i], 1'b1);
         wait_drain();
      end

      // Start pulsed mid-compare with different operands must be ignored.
      start_cmp(vecs[2], 1'b1);
      cmp_if.Data_A_In      = 8'hFF;
      cmp_if.Data_B_In      = 8'h00;
      cmp_if.Signed_Mode_In = 1'b1;
      cmp_if.Start_In       = 1'b1;
      @(posedge clk); #1;
      cmp_if.Start_In = 1'b0;
      wait_drain();

      // Back-to-back: new start issued in the DONE cycle.
      start_cmp(vecs[0], 1'b1);
      @(posedge clk); #1;
      check("done_before_b2b", int'(cmp_if.Done_Out), 1);
      start_cmp('{8'h00, 8'h40, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1}, 1'b1);
      check("b2b_no_bubble_busy", int'(cmp_if.Busy_Out), 1);
      wait_drain();

      // Reset on the 2nd edge after acceptance aborts the compare.
      start_cmp('{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4}, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_outputs", all_outs(), 0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("no_done_after_abort", int'(cmp_if.Done_Out), 0);
      end
      @(posedge clk); #1;
      start_cmp(model(8'h00, 8'h00, 1'b0), 1'b1);
      wait_drain();

      // Randomised operands against the reference model.
      for (int i = 0; i < 12; i++) begin
         ra = 8'($urandom);
         if (i % 2 == 0)
            v = model(ra, ra ^ (8'h01 << $urandom_range(0, DW - 1)), 1'($urandom_range(0, 1)));
         else
            v = model(ra, 8'($urandom), 1'($urandom_range(0, 1)));
         start_cmp(v, 1'b1);
         wait_drain();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, actual running required finished");
      $fatal(1);
   end

endmodule

`default_nettype wire
